// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD countdown timer with load, pause,
// terminal-count pulse and optional auto-reload from a shadow register.
module bcd_down_counter #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick_en,
    output logic [4*DIGITS-1:0]   q,
    output logic                  running,
    output logic                  done,
    output logic [DIGITS-1:0]     borrow
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [W-1:0]     r_q;
    logic [W-1:0]     w_q_next;
    logic [W-1:0]     r_shadow;
    logic [W-1:0]     w_shadow_next;
    logic             r_done;
    logic             w_done_next;

    logic [W-1:0]     w_q_dec;
    logic [W-1:0]     w_load_clamped;
    logic [DIGITS-1:0] w_dig_en;
    logic [DIGITS-1:0] w_dig_zero;
    logic             w_q_zero;
    logic             w_dec_zero;
    logic             w_dec_fire;

    // Per-digit decrement, borrow chain and load clamping.
    // A digit decrements only when every lower digit is already zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_dig_zero[gi] = (r_q[4*gi +: 4] == 4'd0);

            if (gi == 0) begin : g_en0
                assign w_dig_en[gi] = 1'b1;
            end else begin : g_enn
                assign w_dig_en[gi] = &w_dig_zero[gi-1:0];
            end

            assign w_q_dec[4*gi +: 4] = !w_dig_en[gi]  ? r_q[4*gi +: 4] :
                                        w_dig_zero[gi] ? 4'd9 :
                                                         r_q[4*gi +: 4] - 4'd1;

            assign w_load_clamped[4*gi +: 4] = (load_value[4*gi +: 4] > 4'd9) ?
                                               4'd9 : load_value[4*gi +: 4];

            assign borrow[gi] = w_dec_fire & w_dig_en[gi] & w_dig_zero[gi];
        end
    endgenerate

    assign w_q_zero   = (r_q == '0);
    assign w_dec_zero = (w_q_dec == '0);
    // A real decrement happens this cycle (zero is never decremented past).
    assign w_dec_fire = (r_state == S_RUN) & tick_en & ~pause & ~load & ~w_q_zero;

    // Next-state, next-count and done-pulse decode; load overrides everything.
    always_comb begin
        w_state_next  = r_state;
        w_q_next      = r_q;
        w_shadow_next = r_shadow;
        w_done_next   = 1'b0;
        if (load) begin
            w_q_next      = w_load_clamped;
            w_shadow_next = w_load_clamped;
            w_state_next  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_q_zero) begin
                            w_state_next = S_EXPIRED;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_next = S_PAUSED;
                    end else if (tick_en) begin
                        if (w_q_zero) begin
                            w_state_next = S_EXPIRED;
                            w_done_next  = 1'b1;
                        end else begin
                            w_q_next = w_q_dec;
                            if (w_dec_zero) begin
                                w_state_next = S_EXPIRED;
                                w_done_next  = 1'b1;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (start && !pause) begin
                        w_state_next = S_RUN;
                    end
                end
                S_EXPIRED: begin
                    if (AUTO_RELOAD) begin
                        if (r_shadow != '0) begin
                            w_q_next     = r_shadow;
                            w_state_next = S_RUN;
                        end
                    end else if (start && !w_q_zero) begin
                        w_state_next = S_RUN;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // State, count, shadow and done registers; reset aborts any count at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_shadow <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_q      <= w_q_next;
            r_shadow <= w_shadow_next;
            r_done   <= w_done_next;
        end
    end

    assign q       = r_q;
    assign running = (r_state == S_RUN);
    assign done    = r_done;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed testbench for bcd_down_counter: one instance without and one with
// auto-reload, both two digits wide.
module tb_bcd_down_counter;

    logic       clk;
    logic       reset;

    logic       load, start, pause, tick_en;
    logic [7:0] load_value;
    logic [7:0] q;
    logic       running, done;
    logic [1:0] borrow;

    logic       a_load, a_start, a_pause, a_tick_en;
    logic [7:0] a_load_value;
    logic [7:0] a_q;
    logic       a_running, a_done;
    logic [1:0] a_borrow;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .tick_en(tick_en),
        .q(q), .running(running), .done(done), .borrow(borrow)
    );

    bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .reset(reset), .load(a_load), .load_value(a_load_value),
        .start(a_start), .pause(a_pause), .tick_en(a_tick_en),
        .q(a_q), .running(a_running), .done(a_done), .borrow(a_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; pause = 0; tick_en = 0; load_value = 8'h00;
        a_load = 0; a_start = 0; a_pause = 0; a_tick_en = 0; a_load_value = 8'h00;
    endtask

    task automatic load_and_start(input logic [7:0] v);
        load = 1; load_value = v; cyc();
        load = 0; start = 1; cyc();
        start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        cyc(); cyc();
        n_checks++;
        if (q !== 8'h00 || running !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: q=%h running=%b done=%b, want q=00 running=0 done=0", q, running, done);
        end
        reset = 1;
        cyc();
        $display("test_reset: q=%h running=%b done=%b", q, running, done);
    endtask

    task automatic test_reset_mid_count();
        load_and_start(8'h25);
        tick_en = 1;
        cyc(); cyc(); cyc();
        tick_en = 0;
        n_checks++;
        if (q !== 8'h22 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_count_value: q=%h running=%b, want q=22 running=1", q, running);
        end
        #2 reset = 0;
        #1;
        n_checks++;
        if (q !== 8'h00 || running !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: q=%h running=%b done=%b, want 00 0 0", q, running, done);
        end
        cyc();
        reset = 1;
        cyc(); cyc();
        n_checks++;
        if (done !== 1'b0 || q !== 8'h00 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: q=%h running=%b done=%b, want 00 0 0", q, running, done);
        end
        $display("test_reset_mid_count: q=%h after reset", q);
    endtask

    task automatic test_borrow_expiry();
        logic [7:0] exp_q;
        int done_cnt;
        done_cnt = 0;
        load_and_start(8'h10);
        tick_en = 1;
        #1;
        n_checks++;
        if (borrow !== 2'b01) begin
            n_fail++;
            $display("FAIL borrow_10_to_09: borrow=%b, want 01", borrow);
        end
        for (int i = 9; i >= 0; i--) begin
            cyc();
            exp_q = 8'(i);
            n_checks++;
            if (q !== exp_q) begin
                n_fail++;
                $display("FAIL count_seq: q=%h, want %h", q, exp_q);
            end
            if (done === 1'b1) done_cnt++;
        end
        n_checks++;
        if (done !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_done: done=%b running=%b at q=00, want done=1 running=0", done, running);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (done === 1'b1) done_cnt++;
        end
        tick_en = 0;
        n_checks++;
        if (done_cnt != 1 || q !== 8'h00) begin
            n_fail++;
            $display("FAIL done_once: done pulses=%0d q=%h, want 1 pulse and q=00", done_cnt, q);
        end
        $display("test_borrow_expiry: final q=%h done pulses=%0d", q, done_cnt);
    endtask

    task automatic test_pause();
        load_and_start(8'h05);
        tick_en = 1;
        cyc(); cyc();
        pause = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (q !== 8'h03 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold: q=%h running=%b, want q=03 running=0", q, running);
            end
        end
        start = 1;
        cyc();
        n_checks++;
        if (running !== 1'b0 || q !== 8'h03) begin
            n_fail++;
            $display("FAIL start_plus_pause: running=%b q=%h, want running=0 q=03", running, q);
        end
        pause = 0;
        cyc();
        n_checks++;
        if (running !== 1'b1 || q !== 8'h03) begin
            n_fail++;
            $display("FAIL resume_no_dec: running=%b q=%h, want running=1 q=03", running, q);
        end
        start = 0;
        cyc();
        tick_en = 0;
        n_checks++;
        if (q !== 8'h02) begin
            n_fail++;
            $display("FAIL resume_tick: q=%h, want 02", q);
        end
        $display("test_pause: q=%h running=%b", q, running);
    endtask

    task automatic test_load_priority();
        load_and_start(8'h42);
        tick_en = 1;
        cyc(); cyc();
        n_checks++;
        if (q !== 8'h40) begin
            n_fail++;
            $display("FAIL pre_load_count: q=%h, want 40", q);
        end
        load = 1; load_value = 8'hB7; start = 1;
        cyc();
        load = 0; start = 0; tick_en = 0;
        n_checks++;
        if (q !== 8'h97 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp_priority: q=%h running=%b, want q=97 running=0", q, running);
        end
        tick_en = 1;
        cyc();
        tick_en = 0;
        n_checks++;
        if (q !== 8'h97 || running !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_load: q=%h running=%b done=%b, want 97 0 0", q, running, done);
        end
        load = 1; load_value = 8'hFC;
        cyc();
        load = 0;
        n_checks++;
        if (q !== 8'h99) begin
            n_fail++;
            $display("FAIL clamp_both_digits: q=%h, want 99", q);
        end
        $display("test_load_priority: q=%h running=%b", q, running);
    endtask

    task automatic test_zero_start();
        int run_seen;
        int done_cnt;
        run_seen = 0;
        done_cnt = 0;
        load = 1; load_value = 8'h00;
        cyc();
        load = 0;
        n_checks++;
        if (done !== 1'b0 || q !== 8'h00) begin
            n_fail++;
            $display("FAIL load_zero_no_done: done=%b q=%h, want done=0 q=00", done, q);
        end
        start = 1;
        cyc();
        start = 0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_start_done: done=%b, want 1", done);
        end
        if (done === 1'b1) done_cnt++;
        if (running === 1'b1) run_seen++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (done === 1'b1) done_cnt++;
            if (running === 1'b1) run_seen++;
        end
        n_checks++;
        if (done_cnt != 1 || run_seen != 0 || q !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_start_once: done pulses=%0d running cycles=%0d q=%h, want 1 0 00", done_cnt, run_seen, q);
        end
        $display("test_zero_start: done pulses=%0d", done_cnt);
    endtask

    task automatic test_auto_reload();
        logic [7:0] exp_q;
        logic       exp_done;
        logic       exp_run;
        int         done_cnt;
        done_cnt = 0;
        a_load = 1; a_load_value = 8'h02; cyc();
        a_load = 0; a_start = 1; cyc();
        a_start = 0;
        n_checks++;
        if (a_q !== 8'h02 || a_running !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_start: q=%h running=%b, want 02 1", a_q, a_running);
        end
        a_tick_en = 1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            case (k % 3)
                0:       begin exp_q = 8'h01; exp_done = 1'b0; exp_run = 1'b1; end
                1:       begin exp_q = 8'h00; exp_done = 1'b1; exp_run = 1'b0; end
                default: begin exp_q = 8'h02; exp_done = 1'b0; exp_run = 1'b1; end
            endcase
            if (a_done === 1'b1) done_cnt++;
            n_checks++;
            if (a_q !== exp_q || a_done !== exp_done || a_running !== exp_run) begin
                n_fail++;
                $display("FAIL ar_lap: q=%h done=%b running=%b, want %h %b %b", a_q, a_done, a_running, exp_q, exp_done, exp_run);
            end
        end
        a_tick_en = 0;
        n_checks++;
        if (done_cnt != 2) begin
            n_fail++;
            $display("FAIL ar_done_per_lap: pulses=%0d, want 2", done_cnt);
        end
        // Zero shadow: expire once, then stay put without re-pulsing.
        done_cnt = 0;
        a_load = 1; a_load_value = 8'h00; cyc();
        a_load = 0; a_start = 1; cyc();
        a_start = 0;
        if (a_done === 1'b1) done_cnt++;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (a_done === 1'b1) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 1 || a_running !== 1'b0 || a_q !== 8'h00) begin
            n_fail++;
            $display("FAIL ar_zero_shadow: pulses=%0d running=%b q=%h, want 1 0 00", done_cnt, a_running, a_q);
        end
        $display("test_auto_reload: q=%h", a_q);
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_borrow_expiry();
        test_pause();
        test_load_priority();
        test_zero_start();
        test_auto_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Multi-digit BCD (decade) down-counter with load, pause and terminal-count detection.
- Counts in the opposite direction to the team's decade up-counter: from a loaded BCD value down to 00.
- Intended as a countdown timer feeding the same seven-segment/BCD display path as the up-counter.
- Each digit wraps 0 -> 9 with a borrow into the next digit.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1..4.
- AUTO_RELOAD, 0, when 1 the counter reloads the last loaded value after reaching zero instead of stopping.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  synchronous load strobe.
- load_value  input  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
- start  input  1  begin or resume counting.
- pause  input  1  hold the count while RUN.
- tick_en  input  1  count-enable qualifier (prescaler tick); one decrement per clk with tick_en=1.
- q  output  4*DIGITS  current BCD count.
- running  output  1  high in RUN state.
- done  output  1  one-cycle pulse when the count reaches zero.
- borrow  output  DIGITS  per-digit borrow (digit i is 0 and decrementing), combinational from state and tick_en.

Behaviour:
- Reset (reset=0, asynchronous):
  - q=0, shadow register=0, state=IDLE, running=0, done=0.
  - Reset applied mid-count aborts immediately; no done pulse is produced.
- State machine: states IDLE, RUN, PAUSED, EXPIRED.
  - IDLE: start=1 and q!=0 -> RUN. start with q=0 -> EXPIRED, and done pulses on the next cycle.
  - RUN: decrement on each cycle with tick_en=1 and pause=0.
    - pause=1 -> PAUSED; pause has priority over tick_en in the same cycle.
    - A decrement that produces q=0 -> EXPIRED, and done=1 in the following cycle.
  - PAUSED: start=1 -> RUN, with no decrement in that cycle. The count is held otherwise.
  - EXPIRED:
    - AUTO_RELOAD=0: q stays 0; start with a nonzero q (after a load) -> RUN.
    - AUTO_RELOAD=1: next cycle q=shadow and state=RUN. If shadow=0, the state stays EXPIRED.
- Decrement rule:
  - Digit 0 always decrements.
  - Digit i decrements only when all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
  - The counter never wraps below zero: the 00 -> 99 transition is suppressed and EXPIRED is entered instead.
- Load:
  - load=1 writes load_value to q and to the shadow register in every state, then goes to IDLE; running falls next cycle.
  - Load has priority over start, pause and tick_en in the same cycle.
  - Any digit >9 in load_value is clamped to 9 per digit.
- done:
  - Registered, high for exactly one clk.
  - Not asserted on load of 0.
  - Asserted once per reach-zero event, including each auto-reload lap.
- running=1 only in RUN. q is registered, with one-cycle latency from the tick_en edge to the q change.
- Simultaneous events in the same cycle:
  - load+start: load wins; start is ignored.
  - start+pause in PAUSED: stay PAUSED.

Test Plan:
- Reset mid-count: load 25, start, 3 ticks (q=22), assert reset low asynchronously between edges -> q=00 immediately, running=0, no done pulse.
- Digit borrow and expiry: load 10, start, tick each cycle -> q sequence 10, 09, 08, ..., 01, 00; done pulses exactly once on the cycle after 00; borrow[0]=1 on the 10->09 decrement; q stays 00.
- Pause: load 05, start, tick twice (03), pause=1 with tick_en=1 for 4 cycles -> q holds 03 in PAUSED; start -> RUN, next tick gives 02.
- Load priority and clamp: in RUN at q=40, assert load=1 with load_value=0xB7 and start=1 in the same cycle -> q=97, state IDLE, running=0.
- Auto-reload: AUTO_RELOAD=1, load 02, start, continuous ticks -> q sequence 02, 01, 00, 02, 01, 00, ...; done pulses once per lap.
- Zero start: load 00, start -> EXPIRED, one done pulse, q=00, running never asserted.
